counter_updown_param: RTL and testbench
=======================================

COUNTER_UPDOWN_PARAM -- requirements
Module: counter_updown_param

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning count register width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter MAX_VAL, default 2**WIDTH-1, meaning the top count value (legal range 1..2**WIDTH-1); the count range is 0..MAX_VAL.
REQ-003 The module SHALL have parameter DIV, default 1, meaning the prescale ratio (legal range 1..256); the counter steps once per DIV enabled cycles.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  count enable; also gates the prescaler.
REQ-007 ud  input  1  direction: 1 counts up, 0 counts down.
REQ-008 load  input  1  synchronous parallel load of cin.
REQ-009 cin  input  WIDTH  load value.
REQ-010 mode  input  1  boundary mode: 0 wraps, 1 saturates.
REQ-011 clr_flags  input  1  synchronous clear of the sticky ovf and unf flags.
REQ-012 cn  output  WIDTH  current count, registered.
REQ-013 tc  output  1  one-cycle registered pulse on a boundary event.
REQ-014 ovf  output  1  sticky flag: an up-step was attempted at MAX_VAL.
REQ-015 unf  output  1  sticky flag: a down-step was attempted at 0.

Function
REQ-016 Step qualifier: step = en & tick, where tick is the prescaler terminal; with DIV=1, tick is always 1.
REQ-017 Prescaler: when en=1, it counts 0..DIV-1 and asserts tick while at DIV-1, then wraps to 0; it holds its value when en=0 and clears to 0 on load.
REQ-018 Priority per cycle: load > step > hold.
REQ-019 load SHALL act regardless of en and SHALL take effect on the next edge: cn <= min(cin, MAX_VAL); cin > MAX_VAL clamps to MAX_VAL.
REQ-020 A load SHALL NOT assert tc and SHALL NOT set ovf or unf.
REQ-021 Up-step with cn < MAX_VAL: cn <= cn+1.
REQ-022 Up-step with cn = MAX_VAL: in mode 0, cn <= 0; in mode 1, cn holds; in both modes tc=1 next cycle and ovf <= 1.
REQ-023 Down-step with cn > 0: cn <= cn-1.
REQ-024 Down-step with cn = 0: in mode 0, cn <= MAX_VAL; in mode 1, cn holds; in both modes tc=1 next cycle and unf <= 1.
REQ-025 tc SHALL be high for exactly one cycle per boundary event and low otherwise; continued saturation attempts re-pulse tc on each step.
REQ-026 clr_flags clears ovf and unf on the next edge; a flag-setting event in the same cycle wins, so the flag stays 1.
REQ-027 Changes to ud or mode SHALL take effect on the next step with no extra latency; no arithmetic result SHALL exceed WIDTH bits or MAX_VAL.
REQ-028 Output latency: cn, tc, ovf and unf SHALL all be registered and update 1 clock after the qualifying input edge.

Reset
REQ-029 rst=0 SHALL immediately force cn=0, tc=0, ovf=0, unf=0 and the prescaler to 0, independent of clk.
REQ-030 Reset asserted mid-count SHALL abort any pending step.
REQ-031 After rst deasserts, the first step SHALL occur only after a full DIV enabled cycles.

Structure
REQ-032 A shared package counter_pkg SHALL hold the mode constants MODE_WRAP=0 and MODE_SAT=1 and the legal parameter limits.
REQ-033 One sub-module, counter_prescaler (parameter DIV; ports clk, rst, en, clr, tick), SHALL implement REQ-017; for DIV=1 it degenerates to tick=1.
REQ-034 The top level SHALL hold the count and flag registers and the next-state logic.

Verification (WIDTH=4, MAX_VAL=9, DIV=1 unless stated)
REQ-035 Scenario: rst=0, then rst=1 with en=1, ud=1, mode=0 for 12 cycles -> cn runs 0..9,0,1; tc pulses once at the 9->0 edge; ovf=1.
REQ-036 Scenario: load=1 with cin=4'b1111 -> cn=9 next cycle, tc=0; then ud=0, mode=1, then load cin=1 and 3 steps -> cn goes 1,0,0,0; tc pulses twice; unf=1.
REQ-037 Scenario: load=1, en=1 and the counter at 9 (up, wrap) in the same cycle with cin=5 -> cn=5, tc=0, ovf unchanged.
REQ-038 Scenario: clr_flags=1 in the same cycle as an overflow event -> ovf stays 1; clr_flags=1 alone next cycle -> ovf=0.
REQ-039 Scenario: DIV=3, en=1, ud=1 -> cn increments every 3rd cycle; en=0 for 2 cycles mid-period -> the period stretches by 2 cycles.
REQ-040 Scenario: rst pulsed low asynchronously between clock edges at cn=6 -> cn=0 immediately, before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: boundary-mode encodings and the
// legal parameter ranges.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  localparam int DIV_MIN   = 1;
  localparam int DIV_MAX   = 256;

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: counts 0..DIV-1 while enabled and flags the last
// phase with tick. With DIV=1 the register is pinned at 0, so tick is constant 1.
module counter_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/counter_updown_param.sv
// Parameterised up/down counter with prescaled stepping, wrap/saturate
// boundary handling, one-cycle terminal pulse and sticky over/underflow flags.
module counter_updown_param
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1,
  parameter int          DIV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] cin,
  input  logic             mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] cn,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic tick;
  logic step;
  logic [WIDTH-1:0] load_val;

  counter_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign step     = en & tick;
  assign load_val = (cin > MAXV) ? MAXV : cin;

  // Flag clears are written first so a same-cycle boundary event overrides them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cn  <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr_flags) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (load) begin
        cn <= load_val;
      end else if (step) begin
        if (ud) begin
          if (cn == MAXV) begin
            tc  <= 1'b1;
            ovf <= 1'b1;
            if (mode == MODE_WRAP) cn <= '0;
          end else begin
            cn <= cn + WIDTH'(1);
          end
        end else begin
          if (cn == '0) begin
            tc  <= 1'b1;
            unf <= 1'b1;
            if (mode == MODE_WRAP) cn <= MAXV;
          end else begin
            cn <= cn - WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_updown_param.sv
// Scoreboard bench: two counters (DIV=1 and DIV=3, WIDTH=4, MAX_VAL=9) share
// stimulus; a behavioural model queues expected outputs per clock edge.
module tb_counter_updown_param;

  logic clk, rst, en, ud, load, mode, clr_flags;
  logic [3:0] cin;
  logic [3:0] cn1, cn3;
  logic tc1, ovf1, unf1, tc3, ovf3, unf3;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [3:0] cn;
    logic tc;
    logic ovf;
    logic unf;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } pair_t;

  pair_t q[$];

  int m_cn[2];
  int m_pre[2];
  bit m_tc[2], m_ovf[2], m_unf[2];

  counter_updown_param #(.WIDTH(4), .MAX_VAL(9), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .cin(cin),
    .mode(mode), .clr_flags(clr_flags), .cn(cn1), .tc(tc1), .ovf(ovf1), .unf(unf1)
  );

  counter_updown_param #(.WIDTH(4), .MAX_VAL(9), .DIV(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .cin(cin),
    .mode(mode), .clr_flags(clr_flags), .cn(cn3), .tc(tc3), .ovf(ovf3), .unf(unf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_zero();
    for (int d = 0; d < 2; d++) begin
      m_cn[d] = 0; m_pre[d] = 0; m_tc[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
    end
  endtask

  task automatic model_edge(input int d);
    int div;
    bit tick_m, stp;
    div    = (d == 0) ? 1 : 3;
    tick_m = (m_pre[d] == div - 1);
    stp    = en && tick_m;
    m_tc[d] = 0;
    if (clr_flags) begin
      m_ovf[d] = 0;
      m_unf[d] = 0;
    end
    if (load) begin
      m_cn[d]  = (int'(cin) > 9) ? 9 : int'(cin);
      m_pre[d] = 0;
    end else begin
      if (en) m_pre[d] = (m_pre[d] == div - 1) ? 0 : m_pre[d] + 1;
      if (stp) begin
        if (ud) begin
          if (m_cn[d] == 9) begin
            m_tc[d] = 1; m_ovf[d] = 1;
            if (!mode) m_cn[d] = 0;
          end else m_cn[d] = m_cn[d] + 1;
        end else begin
          if (m_cn[d] == 0) begin
            m_tc[d] = 1; m_unf[d] = 1;
            if (!mode) m_cn[d] = 9;
          end else m_cn[d] = m_cn[d] - 1;
        end
      end
    end
  endtask

  function automatic obs_t pack_model(input int d);
    obs_t o;
    int c;
    c = m_cn[d];
    o.cn  = c[3:0];
    o.tc  = m_tc[d];
    o.ovf = m_ovf[d];
    o.unf = m_unf[d];
    return o;
  endfunction

  task automatic compare_now(input pair_t e);
    chk("cn_div1",  32'(cn1),  32'(e.a.cn));
    chk("tc_div1",  32'(tc1),  32'(e.a.tc));
    chk("ovf_div1", 32'(ovf1), 32'(e.a.ovf));
    chk("unf_div1", 32'(unf1), 32'(e.a.unf));
    chk("cn_div3",  32'(cn3),  32'(e.b.cn));
    chk("tc_div3",  32'(tc3),  32'(e.b.tc));
    chk("ovf_div3", 32'(ovf3), 32'(e.b.ovf));
    chk("unf_div3", 32'(unf3), 32'(e.b.unf));
  endtask

  // One clock: push the model's prediction, then pop it after the edge.
  task automatic cycle();
    pair_t e;
    model_edge(0);
    model_edge(1);
    e.a = pack_model(0);
    e.b = pack_model(1);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      compare_now(e);
    end
  endtask

  task automatic drive(input bit e_i, input bit ud_i, input bit ld_i,
                       input logic [3:0] cin_i, input bit mode_i, input bit clr_i);
    en = e_i; ud = ud_i; load = ld_i; cin = cin_i; mode = mode_i; clr_flags = clr_i;
  endtask

  task automatic check_zero(input string tag);
    pair_t z;
    model_zero();
    z.a = pack_model(0);
    z.b = pack_model(1);
    compare_now(z);
    if (cn1 !== 4'd0) $display("FAIL %s: cn got %0d required 0", tag, cn1);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 4'd0, 0, 0);
    #1 rst = 1'b0;
    #2;
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    model_zero();

    // Count up with wrap through 9 -> 0
    drive(1, 1, 0, 4'd0, 0, 0);
    repeat (12) cycle();

    // Load wins over a same-cycle wrap step; ovf left untouched
    drive(0, 1, 1, 4'd9, 0, 0); cycle();
    drive(1, 1, 1, 4'd5, 0, 0); cycle();

    // Clear racing an overflow event, then a lone clear
    drive(0, 1, 1, 4'd9, 0, 0); cycle();
    drive(1, 1, 0, 4'd0, 0, 1); cycle();
    drive(0, 1, 0, 4'd0, 0, 1); cycle();

    // Clamped load, then saturating down-count through 0
    drive(0, 1, 1, 4'hf, 0, 0); cycle();
    drive(0, 0, 1, 4'd1, 1, 0); cycle();
    drive(1, 0, 0, 4'd0, 1, 0);
    repeat (3) cycle();

    // Prescaled stretch: pause the enable mid-period
    drive(1, 1, 1, 4'd0, 0, 1); cycle();
    drive(1, 1, 0, 4'd0, 0, 0); repeat (4) cycle();
    drive(0, 1, 0, 4'd0, 0, 0); repeat (2) cycle();
    drive(1, 1, 0, 4'd0, 0, 0); repeat (6) cycle();

    // Random mix of all controls
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1),
            ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
            $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
      cycle();
    end

    // Asynchronous reset between edges at cn=6
    drive(0, 1, 1, 4'd6, 0, 0); cycle();
    drive(0, 1, 0, 4'd0, 0, 0);
    chk("cn_before_async", 32'(cn1), 32'd6);
    #2 rst = 1'b0;
    #1;
    check_zero("async_reset");
    #2 rst = 1'b1;

    // First prescaled step only after a full DIV enabled cycles
    drive(1, 1, 0, 4'd0, 0, 0);
    repeat (7) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
